// File: rtl/game_link_if.sv
// game_link_if
//   Bundles the front-end and Pmod link signals of the game link controller.
//   master : mouse/state-machine front end (drives cursor, buttons, link_in)
//   slave  : game_link_ctrl (drives link_out, selection, result and status)
//   Parameter ID_W sets the person ID width; the link word is ID_W+4 bits.
interface game_link_if #(
  parameter int ID_W = 4
) ();
  localparam int LW = ID_W + 4;

  logic [11:0]     xpos;
  logic [11:0]     ypos;
  logic            mouse_right;
  logic            guess_en;
  logic            compare_req;
  logic            clear;
  logic [ID_W-1:0] your_person;
  logic            rst_sys;
  logic [LW-1:0]   link_in;
  logic [LW-1:0]   link_out;
  logic [ID_W-1:0] selected_id;
  logic [1:0]      result;
  logic            result_valid;
  logic            remote_reset;
  logic            link_err;

  modport master (
    output xpos, ypos, mouse_right, guess_en, compare_req, clear,
           your_person, rst_sys, link_in,
    input  link_out, selected_id, result, result_valid, remote_reset, link_err
  );

  modport slave (
    input  xpos, ypos, mouse_right, guess_en, compare_req, clear,
           your_person, rst_sys, link_in,
    output link_out, selected_id, result, result_valid, remote_reset, link_err
  );
endinterface

// File: rtl/game_link_ctrl.sv
// game_link_ctrl
//   Maps a right-click on a GRID_ROWS x GRID_COLS portrait grid to a guessed
//   ID, resolves the guess against the remote board's ID and exchanges IDs,
//   results and reset requests over one link word {id, result, rst_req, present_n}.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - game_link_if.slave: cursor/buttons/game-state inputs, asynchronous
//          link_in, registered link_out, selected_id, result, result_valid,
//          remote_reset and sticky link_err
module game_link_ctrl #(
  parameter int GRID_COLS      = 3,
  parameter int GRID_ROWS      = 3,
  parameter int ID_W           = 4,
  parameter int X0             = 100,
  parameter int Y0             = 100,
  parameter int A_SIDE         = 150,
  parameter int B_SIDE         = 150,
  parameter int X_PITCH        = 200,
  parameter int Y_PITCH        = 200,
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 4,
  parameter int RESET_HOLD     = 16,
  parameter int TIMEOUT_CYCLES = 65_000_000
) (
  input logic       clk,
  input logic       rst,
  game_link_if.slave bus
);
  localparam int LW = ID_W + 4;
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = $clog2(RESET_HOLD + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_WAIT, ST_DONE} state_t;

  // Inclusive span test at 13 bits so lo+side cannot wrap for 12-bit cursors.
  function automatic logic in_span(input logic [11:0] p, input int lo, input int side);
    logic [12:0] p13;
    logic [12:0] lo13;
    logic [12:0] hi13;
    p13  = {1'b0, p};
    lo13 = 13'(lo);
    hi13 = 13'(lo + side);
    return (p13 >= lo13) && (p13 <= hi13);
  endfunction

  logic [LW-1:0]   sync_p0 [SYNC_STAGES];
  logic [LW-1:0]   cand_p1;
  logic [SW-1:0]   stab_cnt_p1;
  logic [LW-1:0]   rx_p1;
  logic            hit;
  logic [ID_W-1:0] hit_id;
  logic            click;
  logic            present;
  logic [ID_W-1:0] rx_id;
  logic [1:0]      rx_res;
  logic            mirror;
  state_t          state;
  logic [ID_W-1:0] sel_id;
  logic [1:0]      res;
  logic            res_vld;
  logic            err;
  logic [TW-1:0]   tcnt;
  logic [HW-1:0]   hold_cnt;
  logic            rst_req;
  logic            rrq_prev;
  logic            rrq_pulse;
  logic [LW-1:0]   link_out_r;

  // ---- stage p0: link input synchroniser (reset to the "absent" pattern)
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p0[i] <= '1;
    end else begin
      sync_p0[0] <= bus.link_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p0[i] <= sync_p0[i-1];
    end
  end

  // ---- stage p1: stability filter; rx follows only a word seen STABLE_CYCLES times in a row
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_p1     <= '1;
      stab_cnt_p1 <= '0;
      rx_p1       <= '1;
    end else if (sync_p0[SYNC_STAGES-1] != cand_p1) begin
      cand_p1     <= sync_p0[SYNC_STAGES-1];
      stab_cnt_p1 <= SW'(1);
    end else if (stab_cnt_p1 < SW'(STABLE_CYCLES - 1)) begin
      stab_cnt_p1 <= stab_cnt_p1 + SW'(1);
    end else begin
      rx_p1 <= cand_p1;
    end
  end

  assign present = ~rx_p1[0];
  assign rx_id   = rx_p1[LW-1:4];
  assign rx_res  = rx_p1[3:2];

  // Hit-test: scanned from the highest ID down so the lowest overlapping ID wins.
  always_comb begin
    hit    = 1'b0;
    hit_id = '0;
    for (int r = GRID_ROWS - 1; r >= 0; r--) begin
      for (int c = GRID_COLS - 1; c >= 0; c--) begin
        if (in_span(bus.xpos, X0 + c * X_PITCH, A_SIDE) &&
            in_span(bus.ypos, Y0 + r * Y_PITCH, B_SIDE)) begin
          hit    = 1'b1;
          hit_id = ID_W'(r * GRID_COLS + c + 1);
        end
      end
    end
  end

  assign click  = bus.guess_en & bus.mouse_right & hit;
  // A result already decided on the remote board is adopted while we have none.
  assign mirror = present && (rx_res == 2'b10 || rx_res == 2'b01) && (res == 2'b00);

  // ---- stage p2: guess FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      sel_id  <= '0;
      res     <= 2'b00;
      res_vld <= 1'b0;
      err     <= 1'b0;
      tcnt    <= '0;
    end else begin
      res_vld <= 1'b0;
      if (bus.clear) begin
        state  <= ST_IDLE;
        sel_id <= '0;
        res    <= 2'b00;
        err    <= 1'b0;
        tcnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (mirror) begin
              res     <= rx_res;
              res_vld <= 1'b1;
              state   <= ST_DONE;
            end else if (click) begin
              sel_id <= hit_id;
              state  <= ST_ARMED;
            end
          end
          ST_ARMED: begin
            if (mirror) begin
              res     <= rx_res;
              res_vld <= 1'b1;
              state   <= ST_DONE;
            end else begin
              if (click) sel_id <= hit_id;
              // WAIT reads sel_id a cycle later, so a same-cycle click is honoured.
              if (bus.compare_req) begin
                tcnt  <= '0;
                state <= ST_WAIT;
              end
            end
          end
          ST_WAIT: begin
            if (present) begin
              res     <= (rx_id == sel_id) ? 2'b10 : 2'b01;
              res_vld <= 1'b1;
              state   <= ST_DONE;
            end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
              err   <= 1'b1;
              tcnt  <= '0;
              state <= ST_ARMED;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
          ST_DONE: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // ---- stage p2: reset-request hold, remote reset edge, outgoing link word
  assign rst_req = (hold_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt   <= '0;
      rrq_prev   <= 1'b0;
      rrq_pulse  <= 1'b0;
      link_out_r <= '0;
    end else begin
      if (bus.rst_sys)     hold_cnt <= HW'(RESET_HOLD);
      else if (rst_req)    hold_cnt <= hold_cnt - HW'(1);
      rrq_prev   <= present & rx_p1[1];
      rrq_pulse  <= present & rx_p1[1] & ~rrq_prev;
      link_out_r <= {bus.your_person, res, rst_req, 1'b0};
    end
  end

  assign bus.link_out     = link_out_r;
  assign bus.selected_id  = sel_id;
  assign bus.result       = res;
  assign bus.result_valid = res_vld;
  assign bus.remote_reset = rrq_pulse;
  assign bus.link_err     = err;
endmodule

// File: tb/tb_game_link_ctrl.sv
// tb_game_link_ctrl
//   Directed-vector bench for game_link_ctrl with TIMEOUT_CYCLES=20 and all
//   other parameters at their defaults (3x3 grid, ID_W=4, 8-bit link word).
module tb_game_link_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   cnt;

  always #5 clk = ~clk;

  game_link_if #(.ID_W(4)) gl ();

  game_link_ctrl #(.TIMEOUT_CYCLES(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (gl.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_link(input logic [7:0] w);
    gl.link_in = w;
    steps(8);
  endtask

  task automatic click(input int x, input int y);
    gl.xpos = 12'(x);
    gl.ypos = 12'(y);
    gl.mouse_right = 1'b1;
    step();
    gl.mouse_right = 1'b0;
  endtask

  task automatic do_clear();
    gl.clear = 1'b1;
    step();
    gl.clear = 1'b0;
  endtask

  task automatic pulse_compare();
    gl.compare_req = 1'b1;
    step();
    gl.compare_req = 1'b0;
  endtask

  initial begin
    gl.xpos = '0; gl.ypos = '0; gl.mouse_right = 1'b0; gl.guess_en = 1'b1;
    gl.compare_req = 1'b0; gl.clear = 1'b0; gl.your_person = 4'd3;
    gl.rst_sys = 1'b0; gl.link_in = 8'hFF;
    steps(3);
    chk("rst_link_out", 32'(gl.link_out), 32'h00);
    chk("rst_sel", 32'(gl.selected_id), 0);
    chk("rst_result", 32'(gl.result), 0);
    chk("rst_rv", 32'(gl.result_valid), 0);
    chk("rst_rr", 32'(gl.remote_reset), 0);
    chk("rst_err", 32'(gl.link_err), 0);
    chk("rst_rx", 32'(dut.rx_p1), 32'hFF);
    rst = 1'b0;

    // Win: remote ID 5, click cell (1,1) -> ID 5
    set_link(8'h50);
    click(300, 300);
    chk("win_sel", 32'(gl.selected_id), 5);
    pulse_compare();
    chk("win_res_early", 32'(gl.result), 0);
    step();
    chk("win_res", 32'(gl.result), 32'b10);
    chk("win_rv", 32'(gl.result_valid), 1);
    step();
    chk("win_rv_drop", 32'(gl.result_valid), 0);
    chk("win_link_out", 32'(gl.link_out), 32'h38);

    // Loss: remote ID 7; clicks in DONE are ignored
    do_clear();
    chk("clr_res", 32'(gl.result), 0);
    chk("clr_sel", 32'(gl.selected_id), 0);
    set_link(8'h70);
    click(300, 300);
    pulse_compare();
    step();
    chk("loss_res", 32'(gl.result), 32'b01);
    click(100, 100);
    chk("done_sel", 32'(gl.selected_id), 5);

    // Hit-test edges
    do_clear(); click(100, 100); chk("hit_100_100", 32'(gl.selected_id), 1);
    do_clear(); click(250, 100); chk("hit_250_100", 32'(gl.selected_id), 1);
    do_clear(); click(251, 100); chk("hit_251_100", 32'(gl.selected_id), 0);
    chk("miss_state", 32'(dut.state), 0);
    do_clear(); click(500, 500); chk("hit_500_500", 32'(gl.selected_id), 9);
    gl.guess_en = 1'b0;
    click(300, 300);
    chk("guess_dis", 32'(gl.selected_id), 9);
    gl.guess_en = 1'b1;
    // clear beats a same-cycle click
    gl.xpos = 12'd300; gl.ypos = 12'd300; gl.mouse_right = 1'b1; gl.clear = 1'b1;
    step();
    gl.mouse_right = 1'b0; gl.clear = 1'b0;
    chk("clear_prio", 32'(gl.selected_id), 0);
    // click + compare together: compare uses the new ID (9 -> 5, remote 5 -> win)
    set_link(8'h50);
    click(500, 500);
    gl.xpos = 12'd300; gl.ypos = 12'd300; gl.mouse_right = 1'b1; gl.compare_req = 1'b1;
    step();
    gl.mouse_right = 1'b0; gl.compare_req = 1'b0;
    chk("cc_sel", 32'(gl.selected_id), 5);
    step();
    chk("cc_res", 32'(gl.result), 32'b10);

    // Glitch filter
    do_clear();
    gl.link_in = 8'h60; steps(3); gl.link_in = 8'h50; steps(8);
    chk("glitch3_rx", 32'(dut.rx_p1), 32'h50);
    gl.link_in = 8'h60; steps(5);
    chk("held_rx_e5", 32'(dut.rx_p1), 32'h50);
    step();
    chk("held_rx_e6", 32'(dut.rx_p1), 32'h60);

    // Presence timeout
    set_link(8'hFF);
    do_clear();
    click(300, 300);
    pulse_compare();
    steps(19);
    chk("tmo_err_early", 32'(gl.link_err), 0);
    step();
    chk("tmo_err", 32'(gl.link_err), 1);
    chk("tmo_state", 32'(dut.state), 1);
    chk("tmo_res", 32'(gl.result), 0);
    do_clear();
    chk("tmo_clr", 32'(gl.link_err), 0);

    // Outgoing reset request hold
    gl.rst_sys = 1'b1; step(); gl.rst_sys = 1'b0;
    chk("rq_first", 32'(gl.link_out[1]), 0);
    cnt = 0;
    for (int i = 0; i < 18; i++) begin
      step();
      if (i == 0) chk("rq_start", 32'(gl.link_out[1]), 1);
      if (gl.link_out[1]) cnt++;
    end
    chk("rq_len", 32'(cnt), 16);

    // Remote reset edge
    gl.link_in = 8'h52;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin step(); if (gl.remote_reset) cnt++; end
    chk("rr_pulses", 32'(cnt), 1);

    // Remote result mirror: 11 ignored, 10 adopted
    set_link(8'h5C);
    steps(2);
    chk("mirror_11", 32'(gl.result), 0);
    gl.link_in = 8'h58;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin step(); if (gl.result_valid) cnt++; end
    chk("mirror_res", 32'(gl.result), 32'b10);
    chk("mirror_rv", 32'(cnt), 1);

    // rst in the middle of WAIT
    set_link(8'hFF);
    do_clear();
    click(300, 300);
    pulse_compare();
    steps(3);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mrst_state", 32'(dut.state), 0);
    chk("mrst_sel", 32'(gl.selected_id), 0);
    chk("mrst_link_out", 32'(gl.link_out), 0);
    chk("mrst_rx", 32'(dut.rx_p1), 32'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/game_link_ctrl.md
# game_link_ctrl

Parametrised inter-board game link controller. It maps a right-click on a ROWS×COLS portrait grid to a guessed ID and exchanges IDs, results and reset requests with the opposite board over one Pmod-width link word. The link word is synchronised and glitch-filtered. Guess resolution is handled by an FSM with a presence timeout. The block sits between the mouse/state-machine front end and the Pmod pins, and replaces the fixed 3×3, unfiltered link logic.

## Interface
Parameters:
- GRID_COLS, 3, portrait columns
- GRID_ROWS, 3, portrait rows; GRID_COLS*GRID_ROWS ≤ 2**ID_W−1
- ID_W, 4, person ID width; ID 0 = none
- X0 / Y0, 100 / 100, top-left pixel of cell (0,0)
- A_SIDE / B_SIDE, 150 / 150, cell width / height in pixels
- X_PITCH / Y_PITCH, 200 / 200, cell-to-cell spacing in pixels
- SYNC_STAGES, 2, link input synchroniser depth (≥2)
- STABLE_CYCLES, 4, consecutive identical samples needed to accept a link word
- RESET_HOLD, 16, cycles the outgoing reset request is held; must be > SYNC_STAGES+STABLE_CYCLES
- TIMEOUT_CYCLES, 65_000_000, presence wait limit in WAIT

Derived: LW = ID_W+4 (link word width).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- xpos, ypos  in  12 each  cursor position
- mouse_right  in  1  right button level
- guess_en  in  1  high while the game state permits selection
- compare_req  in  1  one-cycle pulse: resolve the current selection
- clear  in  1  start/menu state: drop selection, result and error
- your_person  in  ID_W  locally chosen secret ID
- rst_sys  in  1  local request to reset both boards
- link_in  in  LW  word from the remote board (asynchronous)
- link_out  out  LW  word to the remote board
- selected_id  out  ID_W  latched guess
- result  out  2  00 none, 10 win, 01 loss
- result_valid  out  1  one-cycle pulse when result is first set
- remote_reset  out  1  one-cycle pulse on an accepted remote reset request
- link_err  out  1  sticky presence timeout flag

## Operation
- Link word fields, both directions:
  - [LW−1:4] = ID
  - [3:2] = result
  - [1] = reset request
  - [0] = present_n; driven 0, pull-up reads 1 when no board is attached
- link_out is registered: {your_person, result, rst_req, 1'b0}.
- Input path: SYNC_STAGES flops, then a stability counter. The filtered word `rx` updates only after STABLE_CYCLES equal consecutive samples. present = (rx[0]==0).
- Hit-test: cell (r,c) is hit when X0+c·X_PITCH ≤ xpos ≤ X0+c·X_PITCH+A_SIDE and the matching y condition holds; both bounds are inclusive. ID = r·GRID_COLS+c+1. Arithmetic is done at 13 bits, with no overflow for 12-bit inputs. Overlapping cells: the lowest ID wins.
- FSM:
  - IDLE: when guess_en & mouse_right & hit → selected_id=ID, go to ARMED.
  - ARMED: re-clicking updates selected_id. compare_req → WAIT.
  - WAIT: if present, set result = (rx ID == selected_id) ? 10 : 01, pulse result_valid, go to DONE. If not present for TIMEOUT_CYCLES cycles → link_err=1, back to ARMED.
  - DONE: result held; clicks are ignored.
- Remote result mirror: in IDLE or ARMED, when present and rx[3:2] ∈ {10,01} while result==00, result takes rx[3:2], result_valid pulses and the FSM goes to DONE. rx[3:2]=11 is ignored.
- clear: from any state → IDLE. result=00, selected_id=0, link_err=0, timeout counter=0. clear has priority over every other event in the same cycle.
- rst_sys: loads a hold counter with RESET_HOLD. rst_req=1 while the counter is nonzero. Retriggering while active reloads the counter.
- remote_reset: pulses on the 0→1 edge of (present & rx[1]). It does not reset this block itself.

## Timing
- Reset values:
  - link_out={0,00,0,0}; selected_id=0; result=00; result_valid=0; remote_reset=0; link_err=0.
  - FSM=IDLE; filter/hold/timeout counters=0; rx=all-ones (absent).
- Link latency: a link_in change that holds steady shows up in rx after SYNC_STAGES+STABLE_CYCLES cycles. A glitch shorter than STABLE_CYCLES is never accepted.
- Click to selected_id: 1 cycle. compare_req with present already high: result and result_valid appear 1 cycle after entering WAIT, so 2 cycles after the pulse.
- result change to link_out[3:2]: 1 cycle. rst_sys to link_out[1]: 1 cycle, high for exactly RESET_HOLD cycles.
- compare_req outside ARMED is ignored. A simultaneous click and compare_req in ARMED: the click updates the ID first and the compare uses the new ID.
- rst asserted mid-WAIT: next cycle all values return to their reset values.

## Test plan
- Defaults, rx ID=5 present; cursor (300,300), right-click with guess_en → selected_id=5; compare_req → result=10 two cycles later, result_valid one pulse, link_out[3:2]=10.
- Same setup with rx ID=7 → result=01; a further click in DONE leaves selected_id=5.
- Hit-test edges: (100,100) → ID 1; (250,100) → ID 1; (251,100) → no selection; (500,500) → ID 9; mouse_right with guess_en=0 → no change.
- link_in glitch held 3 cycles (STABLE_CYCLES=4) → rx unchanged; held 4 cycles → rx updates 6 cycles after the change.
- TIMEOUT_CYCLES=20 with link_in all-ones, compare_req → link_err=1 after 20 cycles, FSM in ARMED, result=00; clear → link_err=0.
- rst_sys single pulse → link_out[1] high for 16 cycles. Remote rx[1] rising with present → remote_reset is exactly one pulse. Remote rx[3:2]=10 in IDLE → result=10.
